history_fetch: RTL

- Upstream neighbour of the trail IIR stage. Accepts the camera pixel stream with its coordinates and issues a read of the matching pixel from the history frame buffer (BRAM).
- Aligns the returned history pixel with the delayed camera pixel and presents both to the IIR stage with a buffered valid/ready handshake.
- Forwards the frame-buffer address so the downstream write-back can store the IIR result in the same location.

---
 rtl/trail_pkg.sv | 26 ++
 rtl/pair_fifo.sv | 54 +++++
 rtl/history_fetch.sv | 119 +++++++++++
 3 files changed

// File: rtl/trail_pkg.sv
// Shared types and frame geometry for the trail-effect pipeline.
// Camera and history pixels are packed Y/Cb/Cr words.
package trail_pkg;

  localparam int COLOR_DEPTH = 8;
  localparam int Y_W         = 4;
  localparam int CB_W        = 2;
  localparam int CR_W        = 2;

  localparam int H_PIXELS    = 320;
  localparam int V_PIXELS    = 180;
  localparam int ADDR_WIDTH  = 16;

  typedef struct packed {
    logic [COLOR_DEPTH-1:0] camera;
    logic [COLOR_DEPTH-1:0] history;
    logic [ADDR_WIDTH-1:0]  addr;
  } pair_t;

  // Row-major frame-buffer address; H_PIXELS is a constant, so this is a shift-add.
  function automatic logic [ADDR_WIDTH-1:0] pixel_addr(input logic [10:0] hcount,
                                                       input logic [9:0]  vcount);
    return ADDR_WIDTH'(vcount) * ADDR_WIDTH'(H_PIXELS) + ADDR_WIDTH'(hcount);
  endfunction

endpackage

// File: rtl/pair_fifo.sv
// Small synchronous FIFO of camera/history pairs with no internal flow control;
// the caller guarantees it never pushes into a full FIFO or pops an empty one.
module pair_fifo
  import trail_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  logic  pop,
  input  pair_t din,
  output pair_t dout,
  output logic  empty,
  output logic  full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  pair_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/history_fetch.sv
// Issues history frame-buffer reads for in-range camera pixels, aligns the
// returned data with the delayed camera pixel and buffers pairs for the IIR stage.
module history_fetch
  import trail_pkg::*;
#(
  parameter int BRAM_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   cam_valid_in,
  output logic                   cam_ready_out,
  input  logic [COLOR_DEPTH-1:0] cam_pixel_in,
  input  logic [10:0]            cam_hcount_in,
  input  logic [9:0]             cam_vcount_in,
  output logic [ADDR_WIDTH-1:0]  hist_addr_out,
  output logic                   hist_rd_en_out,
  input  logic [COLOR_DEPTH-1:0] hist_data_in,
  output logic                   pair_valid_out,
  input  logic                   pair_ready_in,
  output logic [COLOR_DEPTH-1:0] history_out,
  output logic [COLOR_DEPTH-1:0] camera_out,
  output logic [ADDR_WIDTH-1:0]  addr_out
);

  localparam int CREDIT_W = $clog2(FIFO_DEPTH + 1);

  logic [CREDIT_W-1:0]    credits;
  logic                   first_frame;
  logic                   accept;
  logic                   in_range;
  logic                   issue;
  logic                   last_pixel;
  logic                   pop;
  logic [ADDR_WIDTH-1:0]  rd_addr;

  logic [BRAM_LATENCY-1:0] vld_p;
  logic [BRAM_LATENCY-1:0] zero_p;
  logic [COLOR_DEPTH-1:0]  cam_p  [BRAM_LATENCY];
  logic [ADDR_WIDTH-1:0]   addr_p [BRAM_LATENCY];

  pair_t push_pair;
  pair_t head_pair;
  logic  fifo_push;
  logic  fifo_empty;
  logic  fifo_full;

  // Ready depends only on registered credits, never on pair_ready_in.
  assign cam_ready_out = (credits != '0) && !rst_in;
  assign accept        = cam_valid_in && cam_ready_out;
  assign in_range      = (cam_hcount_in < 11'(H_PIXELS)) && (cam_vcount_in < 10'(V_PIXELS));
  assign issue         = accept && in_range;
  assign last_pixel    = (cam_hcount_in == 11'(H_PIXELS - 1)) &&
                         (cam_vcount_in == 10'(V_PIXELS - 1));
  assign rd_addr       = pixel_addr(cam_hcount_in, cam_vcount_in);

  assign hist_rd_en_out = issue;
  assign hist_addr_out  = issue ? rd_addr : '0;

  assign pop = pair_valid_out && pair_ready_in;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      credits     <= CREDIT_W'(FIFO_DEPTH);
      first_frame <= 1'b1;
      vld_p       <= '0;
    end else begin
      case ({issue, pop})
        2'b10:   credits <= credits - CREDIT_W'(1);
        2'b01:   credits <= credits + CREDIT_W'(1);
        default: ;
      endcase
      // The final pixel of the first frame is still zeroed; it was captured above.
      if (accept && last_pixel) first_frame <= 1'b0;
      vld_p[0] <= issue;
      for (int i = 1; i < BRAM_LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Stage p0..p(BRAM_LATENCY-1): camera side delayed to meet the BRAM read data.
  always_ff @(posedge clk_in) begin
    cam_p[0]  <= cam_pixel_in;
    addr_p[0] <= rd_addr;
    zero_p[0] <= first_frame;
    for (int i = 1; i < BRAM_LATENCY; i++) begin
      cam_p[i]  <= cam_p[i-1];
      addr_p[i] <= addr_p[i-1];
      zero_p[i] <= zero_p[i-1];
    end
  end

  // Stage end: join with hist_data_in and push into the skid FIFO.
  assign fifo_push = vld_p[BRAM_LATENCY-1];
  assign push_pair = '{camera:  cam_p[BRAM_LATENCY-1],
                       history: zero_p[BRAM_LATENCY-1] ? '0 : hist_data_in,
                       addr:    addr_p[BRAM_LATENCY-1]};

  pair_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_pair_fifo (
    .clk   (clk_in),
    .rst   (rst_in),
    .push  (fifo_push),
    .pop   (pop),
    .din   (push_pair),
    .dout  (head_pair),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign pair_valid_out = !fifo_empty;
  assign history_out    = fifo_empty ? '0 : head_pair.history;
  assign camera_out     = fifo_empty ? '0 : head_pair.camera;
  assign addr_out       = fifo_empty ? '0 : head_pair.addr;

  no_overflow: assert property (@(posedge clk_in) disable iff (rst_in)
                                !(fifo_full && fifo_push && !pop));

endmodule
